// File: rtl/fm_demod_sample_strobe_gen.sv
// Decimating sample-strobe generator for the FM demod ADC front end.
// Counts synchronised EOC events and issues round-robin channel strobes.
//   state  | meaning
//   IDLE   | disabled; counter cleared, pointer parked on lowest enabled channel
//   ARM    | enabled; waiting for the first EOC, which is dropped for phase alignment
//   RUN    | counting EOC events and strobing every div_active events
module fm_demod_sample_strobe_gen #(
  parameter int CNT_W   = 8,
  parameter int NUM_CH  = 4,
  parameter int DIV_RST = 10,
  parameter int TO_CYC  = 1024,
  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              RSTn,
  input  logic              en,
  input  logic              eoc,
  input  logic              div_load,
  input  logic [CNT_W-1:0]  div_value,
  input  logic [NUM_CH-1:0] ch_mask,
  input  logic              clr_timeout,
  output logic              sample_stb,
  output logic [CH_W-1:0]   sample_ch,
  output logic [CNT_W-1:0]  div_active,
  output logic              eoc_timeout
);

  localparam int WD_W = (TO_CYC > 2) ? $clog2(TO_CYC) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ARM  = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] shadow;
  logic [CNT_W-1:0] shadow_nxt;
  logic [CNT_W-1:0] div_m1;
  logic [WD_W-1:0]  wd;
  logic [CH_W-1:0]  ptr;
  logic [CH_W-1:0]  ch_pick;
  logic [CH_W-1:0]  ptr_adv;
  logic [CH_W-1:0]  ch_low;
  logic             eoc_s1, eoc_s2, eoc_s3, eoc_evt;
  logic             terminal;
  logic             active;
  logic             wd_sat;
  logic             wd_set;

  // First set bit of m at or after index start, searching cyclically.
  function automatic logic [CH_W-1:0] next_set(input logic [NUM_CH-1:0] m, input int start);
    logic [NUM_CH-1:0] sh;
    int idx;
    next_set = '0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      idx = start + k;
      if (idx >= NUM_CH) idx = idx - NUM_CH;
      sh = m >> idx;
      if (sh[0]) next_set = CH_W'(idx);
    end
  endfunction

  // eoc is asynchronous: two-flop synchroniser, then a registered rising-edge detect.
  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      eoc_s1  <= 1'b0;
      eoc_s2  <= 1'b0;
      eoc_s3  <= 1'b0;
      eoc_evt <= 1'b0;
    end else begin
      eoc_s1  <= eoc;
      eoc_s2  <= eoc_s1;
      eoc_s3  <= eoc_s2;
      eoc_evt <= eoc_s2 & ~eoc_s3;
    end
  end

  assign div_m1     = div_active - CNT_W'(1);
  assign terminal   = (div_active <= CNT_W'(1)) || (cnt >= div_m1);
  assign shadow_nxt = div_load ? div_value : shadow;
  assign ch_low     = next_set(ch_mask, 0);
  assign ch_pick    = next_set(ch_mask, int'(ptr));
  assign ptr_adv    = next_set(ch_mask, int'(ch_pick) + 1);

  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      state      <= S_IDLE;
      cnt        <= '0;
      ptr        <= '0;
      shadow     <= CNT_W'(DIV_RST);
      div_active <= CNT_W'(DIV_RST);
      sample_stb <= 1'b0;
      sample_ch  <= '0;
    end else begin
      sample_stb <= 1'b0;
      shadow     <= shadow_nxt;
      case (state)
        S_IDLE: begin
          cnt        <= '0;
          ptr        <= ch_low;
          div_active <= shadow_nxt;
          if (en) state <= S_ARM;
        end
        S_ARM: begin
          if (!en)          state <= S_IDLE;
          else if (eoc_evt) state <= S_RUN;
        end
        S_RUN: begin
          if (!en) begin
            state <= S_IDLE;
            cnt   <= '0;
          end else if (eoc_evt) begin
            if (terminal) begin
              cnt        <= '0;
              div_active <= shadow_nxt;
              // An empty mask keeps the cadence running but suppresses the strobe.
              if (|ch_mask) begin
                sample_stb <= 1'b1;
                sample_ch  <= ch_pick;
                ptr        <= ptr_adv;
              end
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Watchdog: the flag is set once, on the step into saturation, so a clear sticks.
  assign active = (state != S_IDLE) && en;
  assign wd_sat = (wd == WD_W'(TO_CYC - 1));
  assign wd_set = active && !eoc_evt && (wd == WD_W'(TO_CYC - 2));

  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      wd          <= '0;
      eoc_timeout <= 1'b0;
    end else begin
      if (!active || eoc_evt) wd <= '0;
      else if (!wd_sat)       wd <= wd + WD_W'(1);
      if (wd_set)             eoc_timeout <= 1'b1;
      else if (clr_timeout)   eoc_timeout <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fm_demod_sample_strobe_gen.sv
// Bench for fm_demod_sample_strobe_gen: scenario table, directed corner cases
// and randomized traffic against an event-level reference model.
module tb_fm_demod_sample_strobe_gen;
  localparam int NUM_CH = 4;
  localparam int TO_CYC = 1024;

  logic       clk = 1'b0;
  logic       RSTn, en, eoc, div_load, clr_timeout;
  logic [7:0] div_value;
  logic [3:0] ch_mask;
  logic       sample_stb, eoc_timeout;
  logic [1:0] sample_ch;
  logic [7:0] div_active;

  fm_demod_sample_strobe_gen dut (
    .clk(clk), .RSTn(RSTn), .en(en), .eoc(eoc), .div_load(div_load),
    .div_value(div_value), .ch_mask(ch_mask), .clr_timeout(clr_timeout),
    .sample_stb(sample_stb), .sample_ch(sample_ch), .div_active(div_active),
    .eoc_timeout(eoc_timeout)
  );

  always #5 clk = ~clk;

  typedef enum int {M_IDLE, M_ARM, M_RUN} mode_t;
  typedef struct {
    int         div;
    logic [3:0] mask;
    int         n_eoc;
    int         exp_stb;
    logic [15:0] seq;
  } rec_t;

  int n_cmp = 0, n_err = 0;
  int stb_q[$];

  mode_t      m_mode;
  int         m_cnt, m_shadow, m_div, m_ptr, m_ch, m_quiet;
  bit         m_stb, m_to;
  bit [3:0]   hist;

  task automatic check(string name, int got, int exp);
    n_cmp++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  function automatic int first_set(logic [3:0] m, int start);
    for (int k = 0; k < NUM_CH; k++)
      if (m[(start + k) % NUM_CH]) return (start + k) % NUM_CH;
    return 0;
  endfunction

  task automatic model_reset();
    m_mode = M_IDLE; m_cnt = 0; m_shadow = 10; m_div = 10; m_ptr = 0;
    m_ch = 0; m_quiet = 0; m_stb = 0; m_to = 0; hist = '0;
  endtask

  // One clock edge of behaviour: an EOC rise is counted three edges after it is sampled.
  task automatic model_step();
    bit evt, set;
    int nsh, period, pick;
    if (!RSTn) begin model_reset(); return; end
    evt  = hist[2] & ~hist[3];
    hist = {hist[2:0], eoc};
    nsh  = div_load ? int'(div_value) : m_shadow;
    period = (m_div < 2) ? 1 : m_div;
    set = 0;
    if (m_mode != M_IDLE && en) begin
      if (evt) m_quiet = 0;
      else if (m_quiet < TO_CYC - 1) begin
        m_quiet++;
        if (m_quiet == TO_CYC - 1) set = 1;
      end
    end else m_quiet = 0;
    if (set) m_to = 1;
    else if (clr_timeout) m_to = 0;
    m_stb = 0;
    case (m_mode)
      M_IDLE: begin
        m_cnt = 0; m_ptr = first_set(ch_mask, 0); m_div = nsh;
        if (en) m_mode = M_ARM;
      end
      M_ARM: if (!en) m_mode = M_IDLE; else if (evt) m_mode = M_RUN;
      default: begin
        if (!en) begin m_mode = M_IDLE; m_cnt = 0; end
        else if (evt) begin
          m_cnt++;
          if (m_cnt >= period) begin
            m_cnt = 0; m_div = nsh;
            if (ch_mask != 0) begin
              pick = first_set(ch_mask, m_ptr);
              m_stb = 1; m_ch = pick;
              m_ptr = first_set(ch_mask, (pick + 1) % NUM_CH);
            end
          end
        end
      end
    endcase
    m_shadow = nsh;
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check("stb", int'(sample_stb), int'(m_stb));
    check("ch", int'(sample_ch), m_ch);
    check("div_active", int'(div_active), m_div);
    check("timeout", int'(eoc_timeout), int'(m_to));
    if (sample_stb) stb_q.push_back(int'(sample_ch));
  endtask

  task automatic pulse(int hi, int lo);
    eoc = 1'b1; repeat (hi) step();
    eoc = 1'b0; repeat (lo) step();
  endtask

  task automatic do_reset();
    #2 RSTn = 1'b0;
    #1;
    check("rst_stb", int'(sample_stb), 0);
    check("rst_ch", int'(sample_ch), 0);
    check("rst_div", int'(div_active), 10);
    check("rst_to", int'(eoc_timeout), 0);
    model_reset();
    @(negedge clk);
    en = 0; eoc = 0; div_load = 0; clr_timeout = 0;
    step(); step();
    RSTn = 1'b1;
    step();
  endtask

  task automatic load_div(int d);
    div_value = 8'(d); div_load = 1'b1; step(); div_load = 1'b0;
  endtask

  rec_t tbl[7];
  int hits;

  initial begin
    tbl[0] = '{div: 10,  mask: 4'b1111, n_eoc: 20, exp_stb: 2, seq: 16'h0010};
    tbl[1] = '{div: 1,   mask: 4'b1010, n_eoc: 4,  exp_stb: 4, seq: 16'h3131};
    tbl[2] = '{div: 0,   mask: 4'b1010, n_eoc: 4,  exp_stb: 4, seq: 16'h3131};
    tbl[3] = '{div: 0,   mask: 4'b0000, n_eoc: 5,  exp_stb: 0, seq: 16'h0000};
    tbl[4] = '{div: 3,   mask: 4'b0100, n_eoc: 7,  exp_stb: 2, seq: 16'h0022};
    tbl[5] = '{div: 2,   mask: 4'b1001, n_eoc: 6,  exp_stb: 3, seq: 16'h0030};
    tbl[6] = '{div: 255, mask: 4'b1111, n_eoc: 10, exp_stb: 0, seq: 16'h0000};

    RSTn = 1'b0; en = 0; eoc = 0; div_load = 0; div_value = 0; clr_timeout = 0;
    ch_mask = 4'hF;
    model_reset();
    @(negedge clk);
    do_reset();

    // Scenario table: load ratio while idle, drop the alignment pulse, count strobes.
    for (int t = 0; t < 7; t++) begin
      do_reset();
      ch_mask = tbl[t].mask;
      load_div(tbl[t].div);
      check("div_load_idle", int'(div_active), tbl[t].div);
      en = 1'b1; step();
      pulse(2, 3);
      stb_q.delete();
      repeat (tbl[t].n_eoc) pulse(2, 3);
      repeat (6) step();
      check("tbl_stb_count", stb_q.size(), tbl[t].exp_stb);
      for (int i = 0; i < tbl[t].exp_stb && i < 4 && i < stb_q.size(); i++)
        check("tbl_ch_seq", stb_q[i], int'(tbl[t].seq[4*i +: 4]));
    end

    // Strobe lands 4 clk after the 10th counted EOC rise.
    do_reset();
    ch_mask = 4'hF; en = 1'b1; step();
    pulse(2, 3);
    stb_q.delete();
    repeat (9) pulse(2, 3);
    eoc = 1'b1; step(); step(); step();
    check("stb_before_4clk", int'(sample_stb), 0);
    step();
    check("stb_at_4clk", int'(sample_stb), 1);
    check("stb_first_ch", int'(sample_ch), 0);
    eoc = 1'b0; repeat (3) step();
    repeat (10) pulse(2, 3);
    repeat (6) step();
    check("default_stb_count", stb_q.size(), 2);
    if (stb_q.size() == 2) check("default_second_ch", stb_q[1], 1);

    // Runtime reload waits for the current period to finish.
    do_reset();
    en = 1'b1; step();
    pulse(2, 3);
    stb_q.delete();
    repeat (4) pulse(2, 3);
    load_div(3);
    check("reload_pending", int'(div_active), 10);
    repeat (6) pulse(2, 3);
    repeat (5) step();
    check("reload_first_stb", stb_q.size(), 1);
    check("reload_applied", int'(div_active), 3);
    repeat (3) pulse(2, 3);
    repeat (5) step();
    check("reload_next_stb", stb_q.size(), 2);

    // Watchdog timeout, clear, and set-over-clear priority.
    do_reset();
    en = 1'b1;
    repeat (1023) step();
    check("to_before", int'(eoc_timeout), 0);
    step();
    check("to_set", int'(eoc_timeout), 1);
    clr_timeout = 1'b1; step(); clr_timeout = 1'b0;
    check("to_cleared", int'(eoc_timeout), 0);
    pulse(2, 3);
    clr_timeout = 1'b1;
    hits = 0;
    repeat (1100) begin
      step();
      if (eoc_timeout) hits++;
    end
    clr_timeout = 1'b0;
    check("to_set_wins", hits, 1);

    // en falls on the terminal event: no strobe, block goes back to IDLE.
    do_reset();
    en = 1'b1; step();
    pulse(2, 3);
    stb_q.delete();
    repeat (9) pulse(2, 3);
    eoc = 1'b1; step(); step(); step();
    en = 1'b0; step();
    check("dis_no_stb", int'(sample_stb), 0);
    eoc = 1'b0; repeat (6) step();
    check("dis_stb_count", stb_q.size(), 0);
    load_div(1);
    en = 1'b1; step();
    pulse(2, 3);
    repeat (3) step();
    check("dis_realign_drop", stb_q.size(), 0);
    pulse(2, 3);
    repeat (3) step();
    check("dis_realign_stb", stb_q.size(), 1);

    // Reset in the middle of a count with a strobe pending.
    load_div(5);
    repeat (4) pulse(2, 3);
    stb_q.delete();
    eoc = 1'b1; step(); step(); step();
    do_reset();
    repeat (5) step();
    check("rst_abort_stb", stb_q.size(), 0);
    check("rst_div_after", int'(div_active), 10);

    // Randomized traffic against the model.
    do_reset();
    en = 1'b1;
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 199) == 0) en = ~en;
      if ($urandom_range(0, 2) == 0) eoc = ~eoc;
      div_load = ($urandom_range(0, 49) == 0);
      div_value = 8'($urandom_range(0, 4));
      if ($urandom_range(0, 99) == 0) ch_mask = 4'($urandom);
      clr_timeout = ($urandom_range(0, 19) == 0);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/fm_demod_sample_strobe_gen.md
FM_DEMOD_SAMPLE_STROBE_GEN -- requirements
Module: fm_demod_sample_strobe_gen

Interface
REQ-001 SHALL have parameter CNT_W, default 8, meaning width of the decimation divider and its counter.
REQ-002 SHALL have parameter NUM_CH, default 4, meaning number of demod channels served round-robin; range 1..16.
REQ-003 SHALL have parameter DIV_RST, default 10, meaning divider value loaded at reset.
REQ-004 SHALL have parameter TO_CYC, default 1024, meaning clk cycles without an EOC event before timeout.
REQ-005 SHALL have port clk  input  1  system clock; all logic on its rising edge.
REQ-006 SHALL have port RSTn  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port en  input  1  block enable, synchronous to clk.
REQ-008 SHALL have port eoc  input  1  ADC end-of-conversion, asynchronous to clk.
REQ-009 SHALL have port div_load  input  1  one-cycle request to load div_value into the shadow register.
REQ-010 SHALL have port div_value  input  CNT_W  requested decimation ratio.
REQ-011 SHALL have port ch_mask  input  NUM_CH  per-channel enable for strobe assignment.
REQ-012 SHALL have port clr_timeout  input  1  clears the sticky timeout flag.
REQ-013 SHALL have port sample_stb  output  1  one-cycle sample strobe.
REQ-014 SHALL have port sample_ch  output  max(1,clog2(NUM_CH))  channel index qualified by sample_stb.
REQ-015 SHALL have port div_active  output  CNT_W  divider currently in use.
REQ-016 SHALL have port eoc_timeout  output  1  sticky missing-EOC flag.

Function
REQ-017 SHALL synchronise eoc through two flops and detect a rising edge; eoc_evt is asserted 3 clk cycles after the eoc rise.
REQ-018 SHALL implement states IDLE, ARM and RUN; IDLE->ARM when en=1; ARM->RUN on the first eoc_evt, which is discarded for phase alignment; any state->IDLE when en=0.
REQ-019 SHALL, in IDLE, hold the decimation counter at 0, keep sample_stb at 0, and point the channel pointer at the lowest set bit of ch_mask.
REQ-020 SHALL, in RUN, increment the counter on each eoc_evt; when counter == div_active-1 on an eoc_evt, it clears the counter and drives sample_stb=1 on the next cycle.
REQ-021 SHALL treat div_active values 0 and 1 identically, so that a strobe is issued on every eoc_evt.
REQ-022 SHALL capture div_value into the shadow register on div_load; shadow->div_active transfers at the next terminal count, or immediately when the state is IDLE; the later load wins if two loads occur before transfer.
REQ-023 SHALL, with each strobe, drive sample_ch to the channel pointer, then advance the pointer to the next set bit of ch_mask, wrapping from NUM_CH-1 to 0.
REQ-024 SHALL, when ch_mask=0, suppress sample_stb while the counter continues to run; if the pointer's bit is cleared at strobe time, it uses the next set bit.
REQ-025 SHALL hold sample_ch stable when sample_stb=0 and change it only together with a strobe.
REQ-026 SHALL run the watchdog counter in ARM and RUN, clearing it on eoc_evt; at TO_CYC-1 it sets eoc_timeout and saturates.
REQ-027 SHALL keep eoc_timeout set until clr_timeout=1; when set and clear coincide, set wins; en=0 does not clear the flag.
REQ-028 SHALL, when en falls in the same cycle as a terminal eoc_evt, not issue a strobe.
REQ-029 SHALL set the counter width to CNT_W and let no counter wrap past div_active-1.

Reset
REQ-030 SHALL, while RSTn=0 (asynchronously), force state=IDLE, counter=0, watchdog=0, pointer=0, shadow=div_active=DIV_RST, sample_stb=0, sample_ch=0, eoc_timeout=0 and sync flops=0.
REQ-031 SHALL synchronise reset release externally; RSTn asserted mid-operation aborts any pending strobe.

Verification
REQ-032 SHALL cover the default case: en=1, ch_mask=4'b1111, 21 eoc pulses gives 1 discarded pulse and then 2 strobes with sample_ch 0 then 1, each strobe 4 clk after its 10th counted eoc rise.
REQ-033 SHALL cover runtime reload: div_load with div_value=3 mid-count gives the current period of 10 completed, then strobes every 3 eoc, with div_active=3 after the terminal count.
REQ-034 SHALL cover a sparse mask: ch_mask=4'b1010 with div=1 gives a sample_ch sequence of 1,3,1,3; ch_mask=0 gives no strobes.
REQ-035 SHALL cover timeout: en=1 with no eoc for 1024 clk sets eoc_timeout; clr_timeout asserted together with a new timeout keeps it 1.
REQ-036 SHALL cover disable and reset: en=0 on a terminal eoc gives no strobe and state IDLE; RSTn pulse mid-count gives all outputs at reset values and div_active=10.
